// File: rtl/seg_scan.sv
// Multiplexed common-anode seven-segment driver with per-frame snapshot,
// blink, leading-zero blanking, decimal points and inter-digit dead time.
module seg_scan #(
    parameter int               DIGITS       = 6,
    parameter int               SCAN_DIV     = 4,
    parameter int               BLINK_FRAMES = 8,
    parameter int               LZ_BLANK     = 1,
    parameter logic [DIGITS-1:0] DP_MASK     = 6'b010100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   raw_segs,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int IW = $clog2(DIGITS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [DW-1:0]         div_cnt_q, div_cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   snap_q, snap_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic                  blink_q, blink_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  tick;
    logic                  frame_end;
    logic [3:0]            digit;
    logic [6:0]            glyph;
    logic                  blanked;
    logic                  lit;

    always_comb begin
        div_cnt_d = div_cnt_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        frame_d   = frame_q;
        blink_d   = blink_q;

        tick      = en && (div_cnt_q == DIV_LAST);
        frame_end = tick && (idx_q == IDX_LAST);

        if (en) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        end
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        // Snapshot at frame end so a digit change never tears a frame
        if (frame_end) begin
            snap_d = raw_segs;
            if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    always_comb begin
        digit = 4'(snap_q >> {idx_q, 2'b00});
        glyph = 7'b0111111;
        case (digit)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b0111111;
        endcase
    end

    always_comb begin
        blanked = (blink_q && blink_mask[idx_q])
               || ((LZ_BLANK != 0) && (idx_q == IDX_LAST)
                   && (digit == 4'd0));
        // First cycle of each slot is dead time against ghosting
        lit  = en && (div_cnt_q != '0) && !blanked;
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (lit) begin
            an_d  = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_q);
            seg_d = glyph;
            dp_d  = ~DP_MASK[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            frame_q   <= '0;
            blink_q   <= 1'b0;
            an_q      <= '1;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            frame_q   <= frame_d;
            blink_q   <= blink_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: a frame-position model predicts each
// registered output cycle, queued at drive time and compared one cycle later.
module tb_seg_scan;

    localparam int D   = 6;
    localparam int SD  = 4;
    localparam int BF  = 2;
    localparam int FR  = D * SD;
    localparam logic [5:0] DPM = 6'b010100;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [23:0] raw;
    logic [5:0]  bm;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;

    out_t        sb[$];
    int          m_pos;
    int          m_frames;
    logic [23:0] m_snap;
    int          n_chk;
    int          n_pass;

    seg_scan #(
        .DIGITS      (D),
        .SCAN_DIV    (SD),
        .BLINK_FRAMES(BF),
        .LZ_BLANK    (1),
        .DP_MASK     (DPM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .raw_segs   (raw),
        .blink_mask (bm),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] v);
        logic [6:0] tbl [0:9];
        tbl[0] = 7'b1000000; tbl[1] = 7'b1111001;
        tbl[2] = 7'b0100100; tbl[3] = 7'b0110000;
        tbl[4] = 7'b0011001; tbl[5] = 7'b0010010;
        tbl[6] = 7'b0000010; tbl[7] = 7'b1111000;
        tbl[8] = 7'b0000000; tbl[9] = 7'b0010000;
        return (v > 4'd9) ? 7'b0111111 : tbl[v];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want,
                      $time);
    endtask

    function automatic out_t model_out();
        out_t o;
        int idx;
        int slot_pos;
        logic [3:0] v;
        logic phase;
        o.an  = 6'h3F;
        o.seg = 7'h7F;
        o.dp  = 1'b1;
        if (reset || !en) return o;
        idx      = m_pos / SD;
        slot_pos = m_pos % SD;
        v        = m_snap[idx*4 +: 4];
        phase    = ((m_frames / BF) % 2) == 1;
        if (slot_pos == 0) return o;
        if (phase && bm[idx]) return o;
        if (idx == D - 1 && v == 4'd0) return o;
        o.an      = 6'h3F;
        o.an[idx] = 1'b0;
        o.seg     = dec(v);
        o.dp      = ~DPM[idx];
        return o;
    endfunction

    task automatic model_update();
        if (reset) begin
            m_pos    = 0;
            m_frames = 0;
            m_snap   = '0;
        end else if (en) begin
            if (m_pos == FR - 1) begin
                m_pos  = 0;
                m_snap = raw;
                m_frames++;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic step();
        out_t want;
        sb.push_back(model_out());
        @(posedge clk);
        model_update();
        @(negedge clk);
        want = sb.pop_front();
        chk("an",  32'(an),  32'(want.an));
        chk("seg", 32'(seg), 32'(want.seg));
        chk("dp",  32'(dp),  32'(want.dp));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        run(n);
        reset = 1'b0;
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        m_pos    = 0;
        m_frames = 0;
        m_snap   = '0;
        reset    = 1'b1;
        en       = 1'b1;
        raw      = 24'h235959;
        bm       = 6'b0;
        @(negedge clk);

        // reset held with en high, then frames of 23:59:59
        do_reset(3);
        chk("rst_an",  32'(an),  32'h3F);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp",  32'(dp),  32'h1);
        run(3 * FR);

        // mid-frame change must not appear until after next frame end
        raw = 24'h120000;
        do_reset(1);
        run(FR + 12);
        raw = 24'h120001;
        run(3 * FR);

        // en drop at div_cnt=2, idx=3
        begin
            int guard = 0;
            while (m_pos != 3 * SD + 2 && guard < 2 * FR) begin
                step();
                guard++;
            end
            chk("en_sync_pos", 32'(m_pos), 32'(3 * SD + 2));
        end
        en = 1'b0;
        run(10);
        en = 1'b1;
        run(2 * FR);

        // reset mid-frame, and reset while disabled
        run(7);
        do_reset(1);
        run(FR + 5);
        en = 1'b0;
        do_reset(2);
        en = 1'b1;
        run(FR);

        // blink on digits 0/1 with a dash on digit 0
        raw = 24'h12345A;
        bm  = 6'b000011;
        do_reset(1);
        run(10 * FR);
        bm = 6'b0;
        run(FR);

        // random digits including non-BCD values
        for (int k = 0; k < 4; k++) begin
            raw = 24'($urandom);
            bm  = 6'($urandom);
            run(FR + 7);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed seven-segment display driver that sits directly downstream of the clock/traffic-light top. It consumes the packed BCD digit bus (hours/minutes/seconds, `raw_segs`) and drives a common-anode multi-digit display, one digit at a time. Each frame of digits is snapshotted so a digit change mid-scan never tears the display. It adds blink, leading-zero blanking, decimal-point separators and inter-digit dead time against ghosting.

## Interface
- `DIGITS`, 6, number of display digits (≥2)
- `SCAN_DIV`, 4, clock cycles per digit slot (≥2)
- `BLINK_FRAMES`, 8, frames per blink half-period (≥1)
- `LZ_BLANK`, 1, blank the most significant digit when its value is 0
- `DP_MASK`, 6'b010100, per-digit decimal point enable (bit i = digit i)

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `en`  in  1  display/scan enable
- `raw_segs`  in  4*DIGITS  packed BCD digits; `[3:0]` = digit 0 (rightmost, seconds low), `[4*DIGITS-1 -: 4]` = most significant
- `blink_mask`  in  DIGITS  digits to blink
- `an`  out  DIGITS  anode selects, active-low
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low
- `dp`  out  1  decimal point, active-low

## Operation
- Reset: `div_cnt`=0, `idx`=0, snapshot=0, frame counter=0, `blink_phase`=0; `an`=all 1, `seg`=7'h7F, `dp`=1.
- `div_cnt` counts 0..SCAN_DIV-1 while `en`=1, wrapping to 0; `tick` = `en` && `div_cnt`==SCAN_DIV-1.
- On `tick`: `idx` advances 0→1→…→DIGITS-1→0.
- Frame end = `tick` with `idx`==DIGITS-1: snapshot ← `raw_segs`; frame counter increments; when it reaches BLINK_FRAMES-1 it wraps to 0 and `blink_phase` toggles.
- Digit value = snapshot nibble `idx`. Decode: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000; 10–15→0111111 (dash, g only).
- Digit blanked (anode off) when: `blink_phase`=1 and `blink_mask[idx]`=1; or LZ_BLANK=1, `idx`==DIGITS-1, value==0.
- Dead time: during `div_cnt`==0 of every slot all anodes off.
- Active slot cycle (`div_cnt`≥1, not blanked): `an` = all 1 except bit `idx` = 0; `seg` = decode; `dp` = ~DP_MASK[idx].
- Whenever anodes are off: `seg`=7'h7F, `dp`=1.
- `en`=0: all counters, `idx`, snapshot and blink state hold; outputs all off. On `en` re-assertion scan resumes at held `div_cnt`/`idx`.
- `blink_mask` sampled live (not snapshotted).

## Timing
- All outputs registered: outputs in cycle n+1 reflect state (`div_cnt`,`idx`,snapshot,`en`) in cycle n.
- Slot = SCAN_DIV cycles: 1 dead + SCAN_DIV-1 lit. Frame = DIGITS×SCAN_DIV cycles (24 default).
- `raw_segs` change is displayed at the start of the first frame beginning after the next frame end; worst-case latency ≈ 2 frames.
- First frame after reset displays snapshot 0 (all zeros, MSD blanked if LZ_BLANK).
- `reset` mid-frame: next cycle returns to reset state regardless of `en`.
- `reset` and `en` simultaneous: reset wins.

## Test plan
- Reset held 3 cycles with `en`=1 → `an`=6'h3F, `seg`=7'h7F, `dp`=1 during and one cycle after release.
- `raw_segs`=24'h235959, defaults → frame 1 shows 0,0,0,0,0,blank; frame 2 (from cycle 24 after reset release, +1 output latency) digit 0 `seg`=0010000 (9), digit 5 `seg`=0100100 (2); `dp`=0 only on digits 2 and 4.
- Slot 0 of any frame → `an`=6'h3F for 1 cycle, then 6'b111110 for 3 cycles; slot 1 → 6'b111101.
- Change `raw_segs` from 24'h120000 to 24'h120001 at mid-frame → digit 0 still shows 0 for rest of frame and all of next frame's... shows 1 only from the frame after the next frame end.
- Drop `en` for 10 cycles at `div_cnt`=2, `idx`=3 → outputs all off next cycle; after re-assertion slot 3 continues from `div_cnt`=2 (2 more lit cycles).
- `blink_mask`=6'b000011, BLINK_FRAMES=2, nibble 0 = 4'hA → digit 0 shows 0111111 for 2 frames, blanked 2 frames, repeating; digit 2 never blanks.
